// File: rtl/link_mm_pkg.sv
// Shared types and constants for the link MM request bridge.
package link_mm_pkg;

  localparam int LINK_ADDR_W = 17;
  localparam int LINK_DATA_W = 64;
  localparam logic [63:0] MM_ERR_PATTERN = 64'hDEAD_BEEF_DEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/mm_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module mm_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/link_mm_bridge.sv
// Single-outstanding host-to-decoder request sequencer with read timeout.
// All outputs are registered; next-cycle values are derived from the next state.
module link_mm_bridge
  import link_mm_pkg::*;
#(
  parameter int ADDR_W  = LINK_ADDR_W,
  parameter int DATA_W  = LINK_DATA_W,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iREQ_V,
  output logic              oREQ_RDY,
  input  logic              iREQ_WR,
  input  logic [ADDR_W-1:0] iREQ_ADDR,
  input  logic [DATA_W-1:0] iREQ_WR_DATA,
  output logic              oRSP_V,
  input  logic              iRSP_RDY,
  output logic [DATA_W-1:0] oRSP_DATA,
  output logic              oRSP_ERR,
  output logic              oMM_WR_EN,
  output logic              oMM_RD_EN,
  output logic [ADDR_W-1:0] oMM_ADDR,
  output logic [DATA_W-1:0] oMM_WR_DATA,
  input  logic [DATA_W-1:0] iMM_RD_DATA,
  input  logic              iMM_RD_DATA_V,
  output logic [15:0]       oTIMEOUT_CNT,
  output logic [7:0]        oSTRAY_CNT
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] mm_addr_d;
  logic [DATA_W-1:0] mm_wr_data_d;
  logic [DATA_W-1:0] rsp_data_d;
  logic              rsp_err_d;
  logic              req_rdy_d, rsp_v_d, mm_wr_en_d, mm_rd_en_d;
  logic              timeout_inc, stray_inc;

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    wr_d         = wr_q;
    mm_addr_d    = oMM_ADDR;
    mm_wr_data_d = oMM_WR_DATA;
    rsp_data_d   = oRSP_DATA;
    rsp_err_d    = oRSP_ERR;
    timeout_inc  = 1'b0;
    stray_inc    = iMM_RD_DATA_V && (state_q != WAIT);

    case (state_q)
      IDLE: begin
        if (iREQ_V && oREQ_RDY) begin
          state_d      = ISSUE;
          wr_d         = iREQ_WR;
          mm_addr_d    = iREQ_ADDR;
          mm_wr_data_d = iREQ_WR_DATA;
        end
      end
      ISSUE: begin
        wait_cnt_d = '0;
        state_d    = wr_q ? IDLE : WAIT;
      end
      WAIT: begin
        wait_cnt_d = wait_cnt_q + CNT_W'(1);
        // A return landing on the timeout cycle still counts as a real completion.
        if (iMM_RD_DATA_V) begin
          rsp_data_d = iMM_RD_DATA;
          rsp_err_d  = 1'b0;
          state_d    = RESP;
        end else if (wait_cnt_q == CNT_LAST) begin
          rsp_data_d  = DATA_W'(MM_ERR_PATTERN);
          rsp_err_d   = 1'b1;
          timeout_inc = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (iRSP_RDY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    req_rdy_d  = (state_d == IDLE);
    rsp_v_d    = (state_d == RESP);
    mm_wr_en_d = (state_d == ISSUE) && wr_d;
    mm_rd_en_d = (state_d == ISSUE) && !wr_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      wr_q        <= 1'b0;
      oREQ_RDY    <= 1'b1;
      oRSP_V      <= 1'b0;
      oRSP_DATA   <= '0;
      oRSP_ERR    <= 1'b0;
      oMM_WR_EN   <= 1'b0;
      oMM_RD_EN   <= 1'b0;
      oMM_ADDR    <= '0;
      oMM_WR_DATA <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      wr_q        <= wr_d;
      oREQ_RDY    <= req_rdy_d;
      oRSP_V      <= rsp_v_d;
      oRSP_DATA   <= rsp_data_d;
      oRSP_ERR    <= rsp_err_d;
      oMM_WR_EN   <= mm_wr_en_d;
      oMM_RD_EN   <= mm_rd_en_d;
      oMM_ADDR    <= mm_addr_d;
      oMM_WR_DATA <= mm_wr_data_d;
    end
  end

  mm_sat_counter #(.W(16)) u_timeout_cnt (
    .clk (clk),
    .clr (!rst_n),
    .inc (timeout_inc),
    .cnt (oTIMEOUT_CNT)
  );

  mm_sat_counter #(.W(8)) u_stray_cnt (
    .clk (clk),
    .clr (!rst_n),
    .inc (stray_inc),
    .cnt (oSTRAY_CNT)
  );

endmodule

// File: doc/link_mm_bridge.md
# link_mm_bridge

Single-outstanding request sequencer between the host register-access channel and the link address decoder. It accepts read/write requests on a valid/ready interface, drives one-cycle MM read/write strobes into the decoder, waits for the read-data-valid return, and presents a held response. A read that gets no response within a programmed bound completes with an error. Writes are posted.

## Interface
- ADDR_W, 17, MM address width
- DATA_W, 64, MM data width
- TIMEOUT, 255, cycles in WAIT before a read is declared lost (≥4)
- clk  in  1  clock
- rst_n  in  1  reset; one clock domain; synchronous, active-low
- iREQ_V  in  1  request valid
- oREQ_RDY  out  1  request accepted when iREQ_V && oREQ_RDY
- iREQ_WR  in  1  1=write, 0=read
- iREQ_ADDR  in  ADDR_W  request address
- iREQ_WR_DATA  in  DATA_W  write data
- oRSP_V  out  1  read response valid, held until iRSP_RDY
- iRSP_RDY  in  1  response consumer ready
- oRSP_DATA  out  DATA_W  read data or error pattern
- oRSP_ERR  out  1  1 = timeout completion
- oMM_WR_EN  out  1  one-cycle write strobe to decoder
- oMM_RD_EN  out  1  one-cycle read strobe to decoder
- oMM_ADDR  out  ADDR_W  address to decoder, held from issue until next accept
- oMM_WR_DATA  out  DATA_W  write data to decoder, held likewise
- iMM_RD_DATA  in  DATA_W  read data from decoder
- iMM_RD_DATA_V  in  1  read data valid from decoder
- oTIMEOUT_CNT  out  16  saturating count of timed-out reads
- oSTRAY_CNT  out  8  saturating count of iMM_RD_DATA_V seen outside WAIT

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP; all outputs registered.
- IDLE: oREQ_RDY=1. On accept, latch addr/data/wr, go ISSUE.
- ISSUE (1 cycle): assert oMM_WR_EN or oMM_RD_EN. Write → IDLE. Read → WAIT, clear wait counter.
- WAIT: counter increments each cycle. iMM_RD_DATA_V=1 → latch iMM_RD_DATA, oRSP_ERR=0, go RESP. Else counter==TIMEOUT-1 → oRSP_DATA=64'hDEAD_BEEF_DEAD_BEEF, oRSP_ERR=1, oTIMEOUT_CNT+1 (saturate at 16'hFFFF), go RESP.
- Data valid and timeout in the same cycle: data wins, no error, counter unchanged.
- RESP: oRSP_V=1, data/err stable. iRSP_RDY=1 → go IDLE; oRSP_V drops next cycle.
- iMM_RD_DATA_V in any state other than WAIT: ignored for data, oSTRAY_CNT+1 (saturate at 8'hFF).
- oREQ_RDY=0 in ISSUE, WAIT, RESP; at most one transaction in flight.
- Reset (sync, rst_n=0 at a clock edge): state IDLE; oREQ_RDY=1 (from first cycle after reset), all other outputs 0, counters 0. An in-flight read is abandoned; its late return counts as stray.

## Timing
- Accept at edge T → strobe high during cycle T+1 (one cycle) → IDLE again at T+2 for writes: write throughput 1 per 2 cycles.
- Read: data valid arriving at cycle T+1+k (k≥1) → oRSP_V high from T+2+k.
- Timeout: oRSP_V high TIMEOUT+1 cycles after strobe cycle with ERR=1.
- Back-to-back reads: min period 3+k cycles plus response-stall cycles.
- Wait counter width $clog2(TIMEOUT+1); no wrap possible since exit at TIMEOUT-1.

## Structure
- Package link_mm_pkg: state enum (IDLE/ISSUE/WAIT/RESP), MM_ERR_PATTERN constant 64'hDEAD_BEEF_DEAD_BEEF, ADDR_W/DATA_W defaults.
- Sub-module mm_sat_counter (parameter width; inc, sync clear, saturating) instanced for oTIMEOUT_CNT and oSTRAY_CNT.

## Test plan
- Write addr 17'h0_2010 data 64'h1234: oMM_WR_EN one cycle with oMM_ADDR=17'h0_2010, oMM_WR_DATA=64'h1234; no oRSP_V; oREQ_RDY back 2 cycles after accept.
- Read addr 17'h0_4008, decoder model returns 64'hCAFE with 3-cycle latency: oRSP_V=1, oRSP_DATA=64'hCAFE, ERR=0; held 5 cycles with iRSP_RDY=0, then released.
- Read with no return, TIMEOUT=8: oRSP_V with 64'hDEAD_BEEF_DEAD_BEEF, ERR=1, 9 cycles after strobe; oTIMEOUT_CNT=1.
- Data valid on exact timeout cycle: ERR=0, real data, oTIMEOUT_CNT unchanged.
- Stray valid pulses in IDLE ×300: oSTRAY_CNT saturates at 8'hFF; no oRSP_V.
- rst_n low for one cycle during WAIT: all outputs 0 except oREQ_RDY=1 next cycle; later return increments oSTRAY_CNT; next read completes normally.
